// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I immediate generator stage.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ImmI     = 3'b000,
    ImmS     = 3'b001,
    ImmB     = 3'b010,
    ImmJ     = 3'b011,
    ImmU     = 3'b100,
    ImmShamt = 3'b101,
    ImmZimm  = 3'b110,
    ImmRsvd  = 3'b111
  } immsrc_e;

  localparam logic [2:0] IMM_RESERVED = 3'b111;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter: (instr, immsrc) -> (imm, illegal).
module imm_format
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] raw;
  logic        sext;
  logic        unused_opcode;

  // Opcode bits never feed an immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw  = '0;
    sext = 1'b1;
    unique case (immsrc_e'(immsrc))
      ImmI:     raw = {{20{instr[31]}}, instr[31:20]};
      ImmS:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:     raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ:     raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      ImmU:     raw = {instr[31:12], 12'b0};
      ImmShamt: begin
        sext = 1'b0;
        raw  = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      end
      ImmZimm:  begin
        sext = 1'b0;
        raw  = {27'b0, instr[19:15]};
      end
      default:  begin
        sext = 1'b0;
        raw  = '0;
      end
    endcase
  end

  assign illegal = (immsrc == IMM_RESERVED);
  assign imm     = sext ? XLEN'($signed(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with one-entry skid buffer.
// Define IMM_TARGET_EN to build the pc + imm target adder.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [XLEN-1:0]  target_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] err_count
);

  logic [XLEN-1:0]  fmt_imm;
  logic             fmt_ill;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  imm_q, skid_imm_q;
  logic             ill_q, skid_ill_q;
  logic [CNT_W-1:0] err_q;
  logic             accept, out_free, load_out, load_skid, cnt_inc;

  imm_format #(
    .XLEN(XLEN)
  ) u_fmt (
    .instr  (instr),
    .immsrc (immsrc),
    .imm    (fmt_imm),
    .illegal(fmt_ill)
  );

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign out_free  = ~out_valid_q | out_ready;
  // Skid is only ever full while the output register is stalled, so a
  // freed output register takes the skid entry first, else the new one.
  assign load_out  = ~flush & out_free & (skid_valid_q | accept);
  assign load_skid = ~flush & ~out_free & accept;
  assign cnt_inc   = accept & fmt_ill & (err_q != '1);

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      out_valid_d  = skid_valid_q | accept;
      skid_valid_d = 1'b0;
    end else begin
      skid_valid_d = skid_valid_q | accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      imm_q        <= '0;
      ill_q        <= 1'b0;
      skid_imm_q   <= '0;
      skid_ill_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (load_out) begin
        imm_q <= skid_valid_q ? skid_imm_q : fmt_imm;
        ill_q <= skid_valid_q ? skid_ill_q : fmt_ill;
      end
      if (load_skid) begin
        skid_imm_q <= fmt_imm;
        skid_ill_q <= fmt_ill;
      end
      if (cnt_inc) begin
        err_q <= err_q + CNT_W'(1);
      end
    end
  end

`ifdef IMM_TARGET_EN
  logic [XLEN-1:0] new_tgt, tgt_q, skid_tgt_q;

  assign new_tgt = pc + fmt_imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= '0;
      skid_tgt_q <= '0;
    end else begin
      if (load_out) begin
        tgt_q <= skid_valid_q ? skid_tgt_q : new_tgt;
      end
      if (load_skid) begin
        skid_tgt_q <= new_tgt;
      end
    end
  end

  assign target_out = tgt_q;
`else
  logic unused_pc;

  assign unused_pc  = ^pc;
  assign target_out = '0;
`endif

  assign out_valid   = out_valid_q;
  assign imm_out     = imm_q;
  assign illegal_out = ill_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage with a field-arithmetic reference model.
module tb_imm_gen_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, illegal_out;
  logic [31:0]      instr;
  logic [2:0]       immsrc;
  logic [XLEN-1:0]  pc, imm_out, target_out;
  logic [CNT_W-1:0] err_count;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  bit   mon_en = 1'b0;

  imm_gen_stage #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .immsrc     (immsrc),
    .pc         (pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .imm_out    (imm_out),
    .target_out (target_out),
    .illegal_out(illegal_out),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Immediate value rebuilt from the field layout using integer arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    longint x;
    longint v;
    logic [63:0] t;
    x = {32'b0, ins};
    v = 0;
    case (sel)
      3'd0: begin
        v = (x >> 20) & 'hFFF;
        if (v >= 2048) v = v - 4096;
      end
      3'd1: begin
        v = ((x >> 25) & 'h7F) * 32 + ((x >> 7) & 'h1F);
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = ((x >> 31) & 1) * 4096 + ((x >> 7) & 1) * 2048 + ((x >> 25) & 'h3F) * 32
            + ((x >> 8) & 'hF) * 2;
        if (v >= 4096) v = v - 8192;
      end
      3'd3: begin
        v = ((x >> 31) & 1) * 1048576 + ((x >> 12) & 'hFF) * 4096 + ((x >> 20) & 1) * 2048
            + ((x >> 21) & 'h3FF) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      3'd4:    v = (x >> 12) * 4096;
      3'd5:    v = (x >> 20) & 31;
      3'd6:    v = (x >> 15) & 31;
      default: v = 0;
    endcase
    t = v;
    return t[31:0];
  endfunction

  // One cycle of stimulus; the accept decision is taken mid-cycle.
  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] s,
                      input logic [31:0] p, input bit rdy, input bit fl,
                      input bit use_exp, input logic [31:0] exp_imm);
    in_valid  = v;
    instr     = ins;
    immsrc    = s;
    pc        = p;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else if (v && in_ready) begin
      exp_t e;
      e.imm = use_exp ? exp_imm : ref_imm(ins, s);
      e.ill = (s == 3'd7);
`ifdef IMM_TARGET_EN
      e.tgt = p + e.imm;
`else
      e.tgt = 32'd0;
`endif
      q.push_back(e);
      if (e.ill && model_cnt < CNT_MAX) model_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit v, input logic [31:0] ins, input logic [2:0] s,
                    input logic [31:0] p, input bit rdy, input bit fl);
    step(v, ins, s, p, rdy, fl, 1'b0, 32'd0);
  endtask

  // Monitor: occupancy, counter and head-of-queue data every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("err_count", err_count, model_cnt);
        if (out_valid && q.size() > 0) begin
          chk("imm_out", imm_out, q[0].imm);
          chk("target_out", target_out, q[0].tgt);
          chk("illegal_out", illegal_out, q[0].ill);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; immsrc = '0; pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm_out", imm_out, 0);
    chk("rst_target_out", target_out, 0);
    chk("rst_illegal_out", illegal_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_count", err_count, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed vectors
    step(1, 32'hFFF00093, 3'd0, 32'h0, 1, 0, 1, 32'hFFFFFFFF);
    step(1, 32'hFE000EE3, 3'd2, 32'h100, 1, 0, 1, 32'hFFFFFFFC);
    step(1, 32'h12345037, 3'd4, 32'h200, 1, 0, 1, 32'h12345000);
    step(1, 32'h41F0D093, 3'd5, 32'h300, 1, 0, 1, 32'h0000001F);
    go(0, 32'h0, 3'd0, 32'h0, 1, 0);

    // Backpressure: second entry lands in the skid register
    step(1, 32'hFFF00093, 3'd0, 32'h40, 0, 0, 1, 32'hFFFFFFFF);
    step(1, 32'h00100093, 3'd0, 32'h44, 0, 0, 1, 32'h00000001);
    go(0, 32'h0, 3'd0, 32'h0, 0, 0);
    repeat (3) go(0, 32'h0, 3'd0, 32'h0, 1, 0);

    // Flush with skid full, and flush with an illegal entry while ready
    go(1, 32'h00500093, 3'd0, 32'h50, 0, 0);
    go(1, 32'h00600093, 3'd0, 32'h54, 0, 0);
    go(1, 32'hDEADBEEF, 3'd7, 32'h58, 0, 1);
    go(1, 32'hDEADBEEF, 3'd7, 32'h5C, 0, 1);
    go(0, 32'h0, 3'd0, 32'h0, 1, 0);

    // Illegal entries and counter saturation
    step(1, 32'hCAFEF00D, 3'd7, 32'h60, 1, 0, 1, 32'h0);
    go(0, 32'h0, 3'd0, 32'h0, 1, 0);
    repeat (20) go(1, $urandom, 3'd7, $urandom, 1, 0);
    go(0, 32'h0, 3'd0, 32'h0, 1, 0);
    @(negedge clk);
    chk("err_saturated", err_count, 4'hF);
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit fl;
      bit rdy;
      fl  = ($urandom_range(0, 39) == 0);
      rdy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      go(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom, rdy, fl);
    end

    repeat (8) go(0, 32'h0, 3'd0, 32'h0, 1, 0);
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
